// File: rtl/mem_block_copy.sv
// Bus-initiator byte copy engine: alternates READ/WRITE over a single-port memory
// bus and keeps a modulo-256 checksum of every byte written.
module mem_block_copy #(
    parameter int addrBusWidth = 13
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [addrBusWidth-1:0] srcAddr,
    input  logic [addrBusWidth-1:0] dstAddr,
    input  logic [addrBusWidth-1:0] length,
    output logic                    busy,
    output logic                    done,
    output logic [7:0]              checksum,
    output logic [addrBusWidth-1:0] memAddr,
    output logic [7:0]              memDataOut,
    input  logic [7:0]              memDataIn,
    output logic                    memWrite,
    output logic                    memStrobe
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [addrBusWidth-1:0] ONE = {{(addrBusWidth-1){1'b0}}, 1'b1};

    state_t                  state;
    logic [addrBusWidth-1:0] src;
    logic [addrBusWidth-1:0] dst;
    logic [addrBusWidth-1:0] remaining;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            src       <= '0;
            dst       <= '0;
            remaining <= '0;
            checksum  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src       <= srcAddr;
                        dst       <= dstAddr;
                        remaining <= length;
                        checksum  <= '0;
                        state     <= (length != '0) ? READ : DONE;
                    end
                end
                READ: begin
                    src   <= src + ONE;
                    state <= WRITE;
                end
                WRITE: begin
                    // memDataIn holds the byte strobed in the preceding READ
                    checksum  <= checksum + memDataIn;
                    dst       <= dst + ONE;
                    remaining <= remaining - ONE;
                    state     <= (remaining != ONE) ? READ : DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Bus is decoded from state so the memory samples it on the closing edge.
    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        memStrobe  = 1'b0;
        memWrite   = 1'b0;
        memAddr    = '0;
        memDataOut = '0;
        case (state)
            READ: begin
                busy      = 1'b1;
                memStrobe = 1'b1;
                memAddr   = src;
            end
            WRITE: begin
                busy       = 1'b1;
                memStrobe  = 1'b1;
                memWrite   = 1'b1;
                memAddr    = dst;
                memDataOut = memDataIn;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_block_copy.sv
// Scoreboard bench for mem_block_copy: a behavioural RAM image predicts every bus
// access and each done pulse; a negedge monitor compares what the DUT presents.
module tb_mem_block_copy;
    localparam int AW  = 13;
    localparam int MSZ = 1 << AW;

    logic          clk = 1'b0;
    logic          reset, start;
    logic [AW-1:0] srcAddr, dstAddr, length;
    logic          busy, done;
    logic [7:0]    checksum;
    logic [AW-1:0] memAddr;
    logic [7:0]    memDataOut, memDataIn;
    logic          memWrite, memStrobe;

    mem_block_copy #(.addrBusWidth(AW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .srcAddr(srcAddr), .dstAddr(dstAddr), .length(length),
        .busy(busy), .done(done), .checksum(checksum),
        .memAddr(memAddr), .memDataOut(memDataOut), .memDataIn(memDataIn),
        .memWrite(memWrite), .memStrobe(memStrobe)
    );

    always #5 clk = ~clk;

    // Memory with registered read data, as seen by the DUT
    logic [7:0] ram     [MSZ];
    logic [7:0] ref_mem [MSZ];
    always @(posedge clk) begin
        if (memStrobe === 1'b1) begin
            if (memWrite === 1'b1) ram[memAddr] <= memDataOut;
            else                   memDataIn    <= ram[memAddr];
        end
    end

    typedef struct { int unsigned a; int unsigned d; } wr_t;
    typedef struct { int unsigned cyc; int unsigned sum; int unsigned len; } dn_t;
    wr_t         exp_wr[$];
    int unsigned exp_rd[$];
    dn_t         exp_dn[$];

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned busy_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: event not expected/seen (cycle %0d)", nm, cyc);
    endtask

    // Monitor: pops predictions whenever the DUT shows an access or a done pulse
    wr_t         mw;
    dn_t         md;
    int unsigned mr;
    always @(negedge clk) begin
        if (memStrobe === 1'b1 && memWrite === 1'b1) begin
            if (exp_wr.size() == 0) fail("unexpected_write");
            else begin
                mw = exp_wr.pop_front();
                chk("wr_addr", memAddr, mw.a);
                chk("wr_data", memDataOut, mw.d);
            end
        end else if (memStrobe === 1'b1) begin
            if (exp_rd.size() == 0) fail("unexpected_read");
            else begin
                mr = exp_rd.pop_front();
                chk("rd_addr", memAddr, mr);
            end
        end else begin
            chk("idle_strobe", memStrobe, 0);
            chk("idle_write", memWrite, 0);
            chk("idle_addr", memAddr, 0);
            chk("idle_data", memDataOut, 0);
        end
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) begin
            if (exp_dn.size() == 0) fail("unexpected_done");
            else begin
                md = exp_dn.pop_front();
                chk("done_cycle", cyc, md.cyc);
                chk("done_checksum", checksum, md.sum);
                chk("busy_cycles", busy_cnt, 2 * md.len);
                chk("busy_in_done", busy, 0);
            end
            busy_cnt = 0;
        end
        if (reset === 1'b1) busy_cnt = 0;
    end

    // Reference copy: byte-by-byte ascending over the RAM image; nb bytes get done
    task automatic issue(input int unsigned s, input int unsigned d, input int unsigned l,
                         input int unsigned nb, input bit with_done);
        int unsigned sum = 0;
        for (int i = 0; i < int'(nb); i++) begin
            int unsigned ra = (s + i) % MSZ;
            int unsigned wa = (d + i) % MSZ;
            logic [7:0]  b  = ref_mem[ra];
            exp_rd.push_back(ra);
            exp_wr.push_back('{wa, b});
            ref_mem[wa] = b;
            sum = (sum + b) % 256;
        end
        if (with_done) exp_dn.push_back('{cyc + 1 + 2 * l, sum, l});
        srcAddr = AW'(s);
        dstAddr = AW'(d);
        length  = AW'(l);
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) fail("timeout_done");
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_checksum"}, checksum, 0);
        chk({tag, "_strobe"}, memStrobe, 0);
        chk({tag, "_write"}, memWrite, 0);
        chk({tag, "_addr"}, memAddr, 0);
        chk({tag, "_dataout"}, memDataOut, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pre3;
        int         mism;
        for (int i = 0; i < MSZ; i++) begin
            logic [7:0] v = 8'($urandom);
            ram[i] = v;
            ref_mem[i] = v;
        end
        reset = 1'b1; start = 1'b0;
        srcAddr = '0; dstAddr = '0; length = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // Basic 4-byte copy
        for (int i = 0; i < 4; i++) begin
            ram[i] = 8'(i + 1);
            ref_mem[i] = 8'(i + 1);
        end
        issue(0, 'h100, 4, 4, 1);
        wait_done();
        chk("basic_checksum", checksum, 8'h0A);
        for (int i = 0; i < 4; i++) chk("basic_dst", ram['h100 + i], i + 1);
        @(negedge clk);

        // Zero length
        issue('h123, 'h456, 0, 0, 1);
        wait_done();
        chk("len0_checksum", checksum, 0);
        @(negedge clk);

        // Address wrap at the top of the space
        ram['h1FFE] = 8'hAA; ram['h1FFF] = 8'hBB; ram[0] = 8'hCC; ram[1] = 8'hDD;
        ref_mem['h1FFE] = 8'hAA; ref_mem['h1FFF] = 8'hBB; ref_mem[0] = 8'hCC; ref_mem[1] = 8'hDD;
        issue('h1FFE, 'h10, 4, 4, 1);
        wait_done();
        chk("wrap_checksum", checksum, 8'h0E);
        chk("wrap_dst0", ram['h10], 8'hAA);
        chk("wrap_dst3", ram['h13], 8'hDD);
        @(negedge clk);

        // Start while busy must be ignored
        issue('h200, 'h300, 6, 6, 1);
        repeat (4) begin
            srcAddr = AW'($urandom); dstAddr = AW'($urandom); length = AW'($urandom_range(1, 9));
            start = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        wait_done();
        @(negedge clk);
        chk("ignored_start_idle", busy, 0);
        @(negedge clk);

        // Reset during the third WRITE of an 8-byte copy
        pre3 = ram['h503];
        issue('h400, 'h500, 8, 3, 0);
        begin
            int n = 0, k = 0;
            while (n < 3 && k < 50) begin
                if (memStrobe === 1'b1 && memWrite === 1'b1) n++;
                if (n < 3) begin @(negedge clk); k++; end
            end
            if (n < 3) fail("timeout_third_write");
        end
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("midreset_dst2", ram['h502], ref_mem['h502]);
        chk("midreset_dst3_untouched", ram['h503], pre3);

        // Random back-to-back copies, some overlapping
        for (int t = 0; t < 12; t++) begin
            int unsigned s = $urandom_range(0, MSZ - 1);
            int unsigned d = (t % 3 == 0) ? (s + $urandom_range(1, 3)) % MSZ
                                          : $urandom_range(0, MSZ - 1);
            int unsigned l = (t == 5) ? 0 : $urandom_range(1, 24);
            issue(s, d, l, l, 1);
            wait_done();
            @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("pending_writes", exp_wr.size(), 0);
        chk("pending_reads", exp_rd.size(), 0);
        chk("pending_dones", exp_dn.size(), 0);
        mism = 0;
        for (int i = 0; i < MSZ; i++) if (ram[i] !== ref_mem[i]) mism++;
        chk("ram_image_diffs", mism, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
